// File: rtl/dmem_arb_pkg.sv
// Shared types for the two-master data-memory arbiter: FSM states, master index,
// and the sizing helper for the optional transfer timeout counter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

    typedef logic master_idx_t;

    // Largest counter ever needed (TIMEOUT_CYCLES tops out at 65535).
    localparam int TMO_CNT_W_MAX = 16;

    function automatic int tmo_cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/riscv_defines.sv
// Core-wide address and data word widths shared by the memory-side blocks.
package riscv_defines;

    localparam int RISCV_ADDR_WIDTH = 32;
    localparam int RISCV_WORD_WIDTH = 32;

endpackage

// File: rtl/dmem_arbiter_pick2.sv
// Combinational two-way winner select: a lone requester wins; ties go to master 0
// under fixed priority, otherwise to the master that did not win last time.
module arb_pick2
    import dmem_arb_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       winner,
    output logic       any
);

    always_comb begin
        any    = |valid;
        winner = 1'b0;
        unique case (valid)
            2'b10:   winner = 1'b1;
            2'b11:   winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
            default: winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single data-memory port (LSU = master 0, debug/DMA = master 1).
// Optional transfer timeout with error flag is enabled by defining DMEM_ARB_TIMEOUT_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
    import riscv_defines::*;
#(
    parameter int FIXED_PRIO     = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        clk,
    input  logic                        rst_n,

    input  logic                        m0_valid_i,
    input  logic [RISCV_ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [RISCV_WORD_WIDTH-1:0] m0_wdata_i,
    input  logic [3:0]                  m0_we_i,
    output logic                        m0_ready_o,
    output logic [RISCV_WORD_WIDTH-1:0] m0_rdata_o,
    output logic                        m0_err_o,

    input  logic                        m1_valid_i,
    input  logic [RISCV_ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [RISCV_WORD_WIDTH-1:0] m1_wdata_i,
    input  logic [3:0]                  m1_we_i,
    output logic                        m1_ready_o,
    output logic [RISCV_WORD_WIDTH-1:0] m1_rdata_o,
    output logic                        m1_err_o,

    output logic                        dmem_valid_o,
    input  logic                        dmem_ready_i,
    output logic [RISCV_ADDR_WIDTH-1:0] dmem_addr_o,
    output logic [RISCV_WORD_WIDTH-1:0] dmem_wdata_o,
    output logic [3:0]                  dmem_we_o,
    input  logic [RISCV_WORD_WIDTH-1:0] dmem_rdata_i
);

    arb_state_e  state;
    master_idx_t last_grant;
    master_idx_t owner;
    logic        granted;
    logic        own_valid;
    logic        tmo_fire;
    logic        done;
    logic        pick_winner;
    logic        pick_any;

    arb_pick2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .valid      ({m1_valid_i, m0_valid_i}),
        .last_grant (last_grant),
        .winner     (pick_winner),
        .any        (pick_any)
    );

    assign granted = (state != IDLE);
    assign owner   = (state == GNT1);

`ifdef DMEM_ARB_TIMEOUT_EN
    localparam int                CNT_W    = tmo_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] tmo_cnt;

    // A requester abort in the same cycle takes precedence over the timeout.
    assign tmo_fire = granted & own_valid & ~dmem_ready_i & (tmo_cnt == TMO_LAST);
`else
    assign tmo_fire = 1'b0;
`endif

    always_comb begin
        own_valid    = granted & (owner ? m1_valid_i : m0_valid_i);
        dmem_valid_o = 1'b0;
        dmem_addr_o  = '0;
        dmem_wdata_o = '0;
        dmem_we_o    = '0;
        if (granted) begin
            dmem_valid_o = own_valid & ~tmo_fire;
            if (owner) begin
                dmem_addr_o  = m1_addr_i;
                dmem_wdata_o = m1_wdata_i;
                dmem_we_o    = m1_we_i;
            end else begin
                dmem_addr_o  = m0_addr_i;
                dmem_wdata_o = m0_wdata_i;
                dmem_we_o    = m0_we_i;
            end
        end
    end

    assign done       = granted & (dmem_ready_i | tmo_fire);
    assign m0_ready_o = done & ~owner;
    assign m1_ready_o = done & owner;
    assign m0_err_o   = tmo_fire & ~owner;
    assign m1_err_o   = tmo_fire & owner;
    assign m0_rdata_o = dmem_rdata_i;
    assign m1_rdata_o = dmem_rdata_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
`ifdef DMEM_ARB_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_any) begin
                        state <= pick_winner ? GNT1 : GNT0;
                    end
                end
                GNT0, GNT1: begin
                    if (dmem_ready_i || tmo_fire) begin
                        last_grant <= owner;
                        state      <= IDLE;
                    end else if (!own_valid) begin
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef DMEM_ARB_TIMEOUT_EN
            // Held at zero while idle, so every grant starts counting from zero.
            if (state == IDLE) begin
                tmo_cnt <= '0;
            end else if (!dmem_ready_i) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
`endif
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench: instance 0 is round-robin, instance 1 fixed priority, both TIMEOUT_CYCLES=4.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        mv  [2][2];
    logic [31:0] ma  [2][2];
    logic [31:0] md  [2][2];
    logic [3:0]  mw  [2][2];
    logic        mr  [2][2];
    logic        me  [2][2];
    logic [31:0] mrd [2][2];
    logic        dv  [2];
    logic        dr  [2];
    logic [31:0] da  [2];
    logic [31:0] dd  [2];
    logic [31:0] drd [2];
    logic [3:0]  dwe [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.FIXED_PRIO(0), .TIMEOUT_CYCLES(4)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .m0_valid_i(mv[0][0]), .m0_addr_i(ma[0][0]), .m0_wdata_i(md[0][0]), .m0_we_i(mw[0][0]),
        .m0_ready_o(mr[0][0]), .m0_rdata_o(mrd[0][0]), .m0_err_o(me[0][0]),
        .m1_valid_i(mv[0][1]), .m1_addr_i(ma[0][1]), .m1_wdata_i(md[0][1]), .m1_we_i(mw[0][1]),
        .m1_ready_o(mr[0][1]), .m1_rdata_o(mrd[0][1]), .m1_err_o(me[0][1]),
        .dmem_valid_o(dv[0]), .dmem_ready_i(dr[0]), .dmem_addr_o(da[0]),
        .dmem_wdata_o(dd[0]), .dmem_we_o(dwe[0]), .dmem_rdata_i(drd[0])
    );

    dmem_arbiter #(.FIXED_PRIO(1), .TIMEOUT_CYCLES(4)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .m0_valid_i(mv[1][0]), .m0_addr_i(ma[1][0]), .m0_wdata_i(md[1][0]), .m0_we_i(mw[1][0]),
        .m0_ready_o(mr[1][0]), .m0_rdata_o(mrd[1][0]), .m0_err_o(me[1][0]),
        .m1_valid_i(mv[1][1]), .m1_addr_i(ma[1][1]), .m1_wdata_i(md[1][1]), .m1_we_i(mw[1][1]),
        .m1_ready_o(mr[1][1]), .m1_rdata_o(mrd[1][1]), .m1_err_o(me[1][1]),
        .dmem_valid_o(dv[1]), .dmem_ready_i(dr[1]), .dmem_addr_o(da[1]),
        .dmem_wdata_o(dd[1]), .dmem_we_o(dwe[1]), .dmem_rdata_i(drd[1])
    );

    // Observed {dmem_valid, m0_ready, m1_ready, m0_err, m1_err} of instance k.
    function automatic logic [4:0] stat(input int k);
        return {dv[k], mr[k][0], mr[k][1], me[k][0], me[k][1]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < 2; k++) begin
            for (int m = 0; m < 2; m++) begin
                mv[k][m] = 1'b0;
                ma[k][m] = '0;
                md[k][m] = '0;
                mw[k][m] = '0;
            end
            dr[k]  = 1'b0;
            drd[k] = '0;
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        for (int k = 0; k < 2; k++) begin
            mv[k][0] = 1'b1; mv[k][1] = 1'b1;
            ma[k][0] = 32'h11; ma[k][1] = 32'h22;
            mw[k][0] = 4'hF;  mw[k][1] = 4'h3;
            dr[k] = 1'b1; drd[k] = 32'hA5A5_5A5A;
        end
        settle();
        for (int k = 0; k < 2; k++) begin
            if ({stat(k), dwe[k], da[k], dd[k]} !== '0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: got st=%b we=%h a=%h d=%h want all 0", k, stat(k), dwe[k], da[k], dd[k]);
            end
            checks++;
            if (mrd[k][0] !== 32'hA5A5_5A5A || mrd[k][1] !== 32'hA5A5_5A5A) begin
                errors++;
                $display("FAIL reset_rdata dut%0d: got %h/%h want a5a55a5a", k, mrd[k][0], mrd[k][1]);
            end
            checks++;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_inputs();
    endtask

    task automatic test_single_read();
        int pulses0 = 0;
        int pulses1 = 0;
        tick();
        mv[0][0] = 1'b1; ma[0][0] = 32'h100; mw[0][0] = 4'h0; md[0][0] = 32'h0;
        dr[0] = 1'b1;  // must be ignored while idle
        settle();
        if (stat(0) !== 5'b00000) begin
            errors++; $display("FAIL single_idle: got %b want 00000", stat(0));
        end
        checks++;
        for (int c = 1; c <= 4; c++) begin
            tick();
            dr[0]  = (c == 4);
            drd[0] = (c == 4) ? 32'hDEAD_BEEF : 32'h1234_5678;
            settle();
            pulses0 += int'(mr[0][0]);
            pulses1 += int'(mr[0][1]);
            if (stat(0) !== {1'b1, c == 4, 3'b000} || da[0] !== 32'h100 || dwe[0] !== 4'h0) begin
                errors++;
                $display("FAIL single_gnt c=%0d: got st=%b a=%h we=%h want st=%b a=100 we=0", c, stat(0), da[0], dwe[0], {1'b1, c == 4, 3'b000});
            end
            checks++;
        end
        if (mrd[0][0] !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL single_rdata: got %h want deadbeef", mrd[0][0]);
        end
        checks++;
        tick();
        clear_inputs();
        settle();
        if (stat(0) !== 5'b00000 || pulses0 != 1 || pulses1 != 0) begin
            errors++;
            $display("FAIL single_done: got st=%b pulses m0=%0d m1=%0d want 00000 1 0", stat(0), pulses0, pulses1);
        end
        checks++;
    endtask

    task automatic test_round_robin();
        int own;
        tick();
        mv[0][0] = 1'b1; ma[0][0] = 32'h200; md[0][0] = 32'hAAAA_0000; mw[0][0] = 4'hF;
        mv[0][1] = 1'b1; ma[0][1] = 32'h300; md[0][1] = 32'hBBBB_0000; mw[0][1] = 4'h4;
        settle();
        if (stat(0) !== 5'b00000) begin
            errors++; $display("FAIL rr_idle0: got %b want 00000", stat(0));
        end
        checks++;
        // m0 won the previous transfer, so the alternation starts with m1.
        for (int t = 0; t < 4; t++) begin
            own = (t % 2 == 0) ? 1 : 0;
            tick();
            dr[0] = 1'b0;
            settle();
            if (stat(0) !== 5'b10000 || dwe[0] !== (own == 1 ? 4'h4 : 4'hF) || da[0] !== (own == 1 ? 32'h300 : 32'h200)) begin
                errors++;
                $display("FAIL rr_gnt t=%0d: got st=%b we=%h a=%h want owner m%0d", t, stat(0), dwe[0], da[0], own);
            end
            checks++;
            tick();
            dr[0] = 1'b1;
            settle();
            if (stat(0) !== {1'b1, own == 0, own == 1, 2'b00} || dd[0] !== (own == 1 ? 32'hBBBB_0000 : 32'hAAAA_0000)) begin
                errors++;
                $display("FAIL rr_done t=%0d: got st=%b d=%h want owner m%0d", t, stat(0), dd[0], own);
            end
            checks++;
            tick();
            if (t == 3) clear_inputs();
            dr[0] = 1'b0;
            settle();
            if (stat(0) !== 5'b00000) begin
                errors++; $display("FAIL rr_gap t=%0d: got %b want 00000", t, stat(0));
            end
            checks++;
        end
    endtask

    task automatic test_fixed_prio();
        tick();
        mv[1][0] = 1'b1; ma[1][0] = 32'h240; mw[1][0] = 4'h3;
        mv[1][1] = 1'b1; ma[1][1] = 32'h340; mw[1][1] = 4'hC;
        settle();
        for (int t = 0; t < 4; t++) begin
            tick();
            dr[1] = 1'b0;
            settle();
            if (stat(1) !== 5'b10000 || da[1] !== 32'h240 || dwe[1] !== 4'h3) begin
                errors++; $display("FAIL fp_gnt t=%0d: got st=%b a=%h we=%h want m0", t, stat(1), da[1], dwe[1]);
            end
            checks++;
            tick();
            dr[1] = 1'b1;
            settle();
            if (stat(1) !== 5'b11000) begin
                errors++; $display("FAIL fp_done t=%0d: got %b want 11000", t, stat(1));
            end
            checks++;
            tick();
            dr[1] = 1'b0;
            if (t == 3) mv[1][0] = 1'b0;
            settle();
        end
        tick();
        settle();
        if (stat(1) !== 5'b10000 || da[1] !== 32'h340 || dwe[1] !== 4'hC) begin
            errors++; $display("FAIL fp_m1_gnt: got st=%b a=%h we=%h want m1", stat(1), da[1], dwe[1]);
        end
        checks++;
        tick();
        dr[1] = 1'b1;
        settle();
        if (stat(1) !== 5'b10100) begin
            errors++; $display("FAIL fp_m1_done: got %b want 10100", stat(1));
        end
        checks++;
        tick();
        clear_inputs();
        settle();
    endtask

    task automatic test_abort();
        tick();
        mv[0][1] = 1'b1; ma[0][1] = 32'h400;
        settle();
        for (int c = 1; c <= 2; c++) begin
            tick();
            settle();
            if (stat(0) !== 5'b10000 || da[0] !== 32'h400) begin
                errors++; $display("FAIL abort_gnt c=%0d: got st=%b a=%h want 10000 400", c, stat(0), da[0]);
            end
            checks++;
        end
        tick();
        mv[0][1] = 1'b0;
        settle();
        if (stat(0) !== 5'b00000) begin
            errors++; $display("FAIL abort_drop: got %b want 00000", stat(0));
        end
        checks++;
        tick();
        mv[0][0] = 1'b1; ma[0][0] = 32'h500;
        mv[0][1] = 1'b1; ma[0][1] = 32'h600;
        settle();
        if (stat(0) !== 5'b00000) begin
            errors++; $display("FAIL abort_idle: got %b want 00000", stat(0));
        end
        checks++;
        // The aborted grant must not have counted as m1's turn.
        tick();
        settle();
        if (stat(0) !== 5'b10000 || da[0] !== 32'h600) begin
            errors++; $display("FAIL abort_tie: got st=%b a=%h want 10000 600", stat(0), da[0]);
        end
        checks++;
        tick();
        dr[0] = 1'b1;
        settle();
        if (stat(0) !== 5'b10100) begin
            errors++; $display("FAIL abort_m1_done: got %b want 10100", stat(0));
        end
        checks++;
        tick();
        dr[0] = 1'b0; mv[0][1] = 1'b0;
        settle();
        tick();
        settle();
        if (stat(0) !== 5'b10000 || da[0] !== 32'h500) begin
            errors++; $display("FAIL abort_m0_gnt: got st=%b a=%h want 10000 500", stat(0), da[0]);
        end
        checks++;
        tick();
        dr[0] = 1'b1;
        settle();
        if (stat(0) !== 5'b11000) begin
            errors++; $display("FAIL abort_m0_done: got %b want 11000", stat(0));
        end
        checks++;
        tick();
        clear_inputs();
        settle();
    endtask

    task automatic test_reset_mid();
        tick();
        mv[0][0] = 1'b1; ma[0][0] = 32'h700; mw[0][0] = 4'h1; md[0][0] = 32'h77;
        settle();
        tick();
        settle();
        if (stat(0) !== 5'b10000) begin
            errors++; $display("FAIL rstmid_gnt: got %b want 10000", stat(0));
        end
        checks++;
        #1;
        rst_n = 1'b0;
        dr[0] = 1'b1;
        #1;
        if ({stat(0), dwe[0], da[0], dd[0]} !== '0) begin
            errors++; $display("FAIL rstmid_outputs: got st=%b we=%h a=%h d=%h want all 0", stat(0), dwe[0], da[0], dd[0]);
        end
        checks++;
        tick();
        rst_n = 1'b1;
        dr[0] = 1'b0;
        mv[0][1] = 1'b1; ma[0][1] = 32'h800;
        settle();
        tick();
        settle();
        if (stat(0) !== 5'b10000 || da[0] !== 32'h700) begin
            errors++; $display("FAIL rstmid_first_tie: got st=%b a=%h want 10000 700", stat(0), da[0]);
        end
        checks++;
        tick();
        dr[0] = 1'b1;
        settle();
        if (stat(0) !== 5'b11000) begin
            errors++; $display("FAIL rstmid_done: got %b want 11000", stat(0));
        end
        checks++;
        tick();
        clear_inputs();
        settle();
    endtask

`ifdef DMEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        tick();
        mv[0][0] = 1'b1; ma[0][0] = 32'h900;
        settle();
        for (int c = 1; c <= 5; c++) begin
            tick();
            settle();
            if (stat(0) !== ((c < 5) ? 5'b10000 : 5'b01010)) begin
                errors++; $display("FAIL timeout_fire c=%0d: got %b want %b", c, stat(0), (c < 5) ? 5'b10000 : 5'b01010);
            end
            checks++;
        end
        tick();
        settle();
        if (stat(0) !== 5'b00000) begin
            errors++; $display("FAIL timeout_idle: got %b want 00000", stat(0));
        end
        checks++;
        for (int c = 1; c <= 5; c++) begin
            tick();
            dr[0] = (c == 5);
            settle();
            if (stat(0) !== ((c < 5) ? 5'b10000 : 5'b11000)) begin
                errors++; $display("FAIL timeout_race c=%0d: got %b want %b", c, stat(0), (c < 5) ? 5'b10000 : 5'b11000);
            end
            checks++;
        end
        tick();
        clear_inputs();
        settle();
    endtask
`endif

    task automatic test_random();
        bit          pend [2][2];
        int          owner [2];
        int          last [2];
        int          gc [2];
        int          lat [2];
        logic [4:0]  e_st;
        logic [31:0] e_a, e_d;
        logic [3:0]  e_we;
        for (int k = 0; k < 2; k++) begin
            owner[k] = -1; gc[k] = 0; lat[k] = 0;
            pend[k][0] = 1'b0; pend[k][1] = 1'b0;
        end
        last[0] = 0;  // m0 completed most recently on the round-robin instance
        last[1] = 1;
        for (int n = 0; n < 400; n++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                for (int m = 0; m < 2; m++) begin
                    if (!pend[k][m] && $urandom_range(2) == 0) begin
                        pend[k][m] = 1'b1;
                        ma[k][m] = $urandom;
                        md[k][m] = $urandom;
                        mw[k][m] = 4'($urandom_range(15));
                    end
                    mv[k][m] = pend[k][m];
                end
                dr[k]  = (owner[k] >= 0) ? (gc[k] == lat[k]) : 1'($urandom_range(1));
                drd[k] = $urandom;
            end
            settle();
            for (int k = 0; k < 2; k++) begin
                e_st = '0; e_a = '0; e_d = '0; e_we = '0;
                if (owner[k] >= 0) begin
                    e_st[4] = mv[k][owner[k]];
                    e_st[3 - owner[k]] = dr[k];
                    e_a  = ma[k][owner[k]];
                    e_d  = md[k][owner[k]];
                    e_we = mw[k][owner[k]];
                end
                if (stat(k) !== e_st) begin
                    errors++; $display("FAIL rand_status dut%0d n=%0d: got %b want %b", k, n, stat(k), e_st);
                end
                checks++;
                if ({da[k], dd[k], dwe[k]} !== {e_a, e_d, e_we}) begin
                    errors++; $display("FAIL rand_bus dut%0d n=%0d: got %h/%h/%h want %h/%h/%h", k, n, da[k], dd[k], dwe[k], e_a, e_d, e_we);
                end
                checks++;
                if (mrd[k][0] !== drd[k] || mrd[k][1] !== drd[k]) begin
                    errors++; $display("FAIL rand_rdata dut%0d n=%0d: got %h/%h want %h", k, n, mrd[k][0], mrd[k][1], drd[k]);
                end
                checks++;
                if (owner[k] < 0) begin
                    if (mv[k][0] || mv[k][1]) begin
                        if (mv[k][0] && !mv[k][1])      owner[k] = 0;
                        else if (!mv[k][0] && mv[k][1]) owner[k] = 1;
                        else if (k == 1)                owner[k] = 0;
                        else                            owner[k] = 1 - last[k];
                        gc[k]  = 0;
                        lat[k] = $urandom_range(2);
                    end
                end else if (dr[k]) begin
                    last[k] = owner[k];
                    pend[k][owner[k]] = 1'b0;
                    owner[k] = -1;
                end else begin
                    gc[k]++;
                end
            end
        end
        tick();
        clear_inputs();
        settle();
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        #2;
        test_reset();
        test_single_read();
        test_round_robin();
        test_fixed_prio();
        test_abort();
        test_reset_mid();
`ifdef DMEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
